// File: rtl/lut_pkg.sv
// Shared constants for the LUT logic unit: truth-table width, named
// functions and the power-on contents of the function table.
package lut_pkg;
    localparam int FUNC_W = 4;

    localparam logic [FUNC_W-1:0] FUNC_AND    = 4'b1000;
    localparam logic [FUNC_W-1:0] FUNC_OR     = 4'b1110;
    localparam logic [FUNC_W-1:0] FUNC_XOR    = 4'b0110;
    localparam logic [FUNC_W-1:0] FUNC_NAND   = 4'b0111;
    localparam logic [FUNC_W-1:0] FUNC_PASS_A = 4'b1100;
    localparam logic [FUNC_W-1:0] FUNC_PASS_B = 4'b1010;

    // Slots past the four named ones come up as constant zero.
    function automatic logic [FUNC_W-1:0] default_func(input int slot);
        case (slot)
            0:       return FUNC_AND;
            1:       return FUNC_OR;
            2:       return FUNC_XOR;
            3:       return FUNC_NAND;
            default: return '0;
        endcase
    endfunction
endpackage

// File: rtl/lut_logic_unit_eval.sv
// Bitwise 2-input truth-table evaluation: r[i] = func[{a[i], b[i]}].
module lut_bitwise_eval
    import lut_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [FUNC_W-1:0] func,
    output logic [WIDTH-1:0]  r
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign r[i] = func[{a[i], b[i]}];
    end
endmodule

// File: rtl/lut_logic_unit.sv
// Pipelined programmable bitwise logic unit: writable truth-table bank,
// valid/ready stream with a single output register, chaining and op counter.
module lut_logic_unit
    import lut_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_FUNCS = 4,
    parameter int CNT_W     = 16,
    parameter int SEL_W     = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_addr,
    input  logic [FUNC_W-1:0] cfg_func,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_chain,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  op_count
);
    logic [NUM_FUNCS-1:0][FUNC_W-1:0] table_q;
    logic                             accept;
    logic                             sel_oob;
    logic                             wr_ok;
    logic [FUNC_W-1:0]                func_sel;
    logic [WIDTH-1:0]                 a_eff;
    logic [WIDTH-1:0]                 eval_r;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign sel_oob  = int'(in_sel) >= NUM_FUNCS;
    assign wr_ok    = int'(cfg_addr) < NUM_FUNCS;
    // An all-zero function forces a zero result for out-of-range selects.
    assign func_sel = sel_oob ? '0 : table_q[in_sel];
    assign a_eff    = in_chain ? out_data : in_a;

    lut_bitwise_eval #(.WIDTH(WIDTH)) u_eval (
        .a    (a_eff),
        .b    (in_b),
        .func (func_sel),
        .r    (eval_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            op_count  <= '0;
            for (int i = 0; i < NUM_FUNCS; i++)
                table_q[i] <= default_func(i);
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= eval_r;
                out_err   <= sel_oob;
                if (op_count != '1)
                    op_count <= op_count + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Table read above sees the pre-edge value, so a same-cycle
            // write only affects later transactions.
            if (cfg_we && wr_ok)
                table_q[cfg_addr] <= cfg_func;
        end
    end
endmodule

// File: tb/tb_lut_logic_unit.sv
// Randomized + directed bench: a default unit and a NUM_FUNCS=3/CNT_W=2 unit
// share one stimulus stream and are each checked against a behavioural model.
module tb_lut_logic_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [3:0] cfg_func = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0, in_b = '0;
    logic [1:0] in_sel = '0;
    logic       in_chain = 1'b0;
    logic       out_ready = 1'b1;

    logic       rdy [2];
    logic       ov  [2];
    logic [7:0] od  [2];
    logic       oe  [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    lut_logic_unit u_dut0 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_func(cfg_func),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .in_chain(in_chain), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .out_err(oe[0]), .op_count(cnt0)
    );

    lut_logic_unit #(.WIDTH(8), .NUM_FUNCS(3), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_func(cfg_func),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .in_chain(in_chain), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .out_err(oe[1]), .op_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model, one copy per unit.
    logic [3:0] mt [2][4];
    bit         mv [2];
    logic [7:0] md [2];
    bit         me [2];
    int         mc [2];
    int         nf [2]   = '{4, 3};
    int         cmax [2] = '{65535, 3};

    // Sum-of-minterms form of the truth table.
    function automatic logic [7:0] lut(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        return (~a & ~b & {8{f[0]}}) | (~a & b & {8{f[1]}}) |
               (a & ~b & {8{f[2]}}) | (a & b & {8{f[3]}});
    endfunction

    task automatic mreset(input int d);
        mv[d] = 0; md[d] = 8'h00; me[d] = 0; mc[d] = 0;
        mt[d][0] = 4'b1000; mt[d][1] = 4'b1110; mt[d][2] = 4'b0110; mt[d][3] = 4'b0111;
    endtask

    task automatic mstep(input int d);
        bit acc, oob;
        logic [7:0] a;
        if (rst) begin
            mreset(d);
        end else begin
            acc = in_valid && (!mv[d] || out_ready);
            if (acc) begin
                a     = in_chain ? md[d] : in_a;
                oob   = int'(in_sel) >= nf[d];
                md[d] = oob ? 8'h00 : lut(mt[d][in_sel], a, in_b);
                me[d] = oob;
                mv[d] = 1;
                if (mc[d] < cmax[d]) mc[d]++;
            end else if (out_ready) begin
                mv[d] = 0;
            end
            if (cfg_we && int'(cfg_addr) < nf[d]) mt[d][cfg_addr] = cfg_func;
        end
    endtask

    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("rdy%0d", d), rdy[d], !mv[d] || out_ready);
        @(posedge clk);
        for (int d = 0; d < 2; d++) mstep(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("valid%0d", d), ov[d], mv[d]);
            chk($sformatf("data%0d", d), od[d], md[d]);
            chk($sformatf("err%0d", d), oe[d], me[d]);
            chk($sformatf("cnt%0d", d), (d == 0) ? 32'(cnt0) : 32'(cnt1), mc[d]);
        end
    endtask

    task automatic drv(input bit v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] s, input bit ch, input bit ordy);
        in_valid = v; in_a = a; in_b = b; in_sel = s; in_chain = ch; out_ready = ordy;
        cfg_we = 1'b0;
    endtask

    logic [15:0] held_cnt;

    initial begin
        for (int d = 0; d < 2; d++) mreset(d);
        rst = 1'b1;
        drv(0, 8'h00, 8'h00, 0, 0, 1);
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", ov[0], 0);
        chk("rst_cnt", cnt0, 0);

        drv(1, 8'hF0, 8'hCC, 0, 0, 1); tick();
        chk("and", od[0], 8'hC0);
        chk("and_cnt", cnt0, 1);

        drv(1, 8'hF0, 8'hCC, 1, 0, 1); tick(); chk("or", od[0], 8'hFC);
        drv(1, 8'hF0, 8'hCC, 2, 0, 1); tick(); chk("xor", od[0], 8'h3C);
        drv(1, 8'hF0, 8'hCC, 3, 0, 1); tick(); chk("nand", od[0], 8'h3F);
        chk("oob_data", od[1], 8'h00);
        chk("oob_err", oe[1], 1);

        // Same-cycle write to the slot being used.
        drv(1, 8'hF0, 8'hCC, 0, 0, 1);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_func = 4'b1100;
        tick(); chk("hazard_old", od[0], 8'hC0);
        drv(1, 8'hF0, 8'hCC, 0, 0, 1); tick(); chk("hazard_new", od[0], 8'hF0);

        drv(1, 8'hFF, 8'h0F, 2, 0, 1); tick(); chk("chain0", od[0], 8'hF0);
        drv(1, 8'h00, 8'hFF, 2, 1, 1); tick(); chk("chain1", od[0], 8'h0F);
        drv(1, 8'h00, 8'h0F, 0, 1, 1); tick(); chk("chain2", od[0], 8'h0F);

        drv(0, 8'h00, 8'h00, 0, 0, 1); tick();
        drv(1, 8'h33, 8'h55, 2, 0, 0); tick(); chk("bp_first", od[0], 8'h66);
        held_cnt = cnt0;
        drv(1, 8'hAA, 8'h55, 2, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready", rdy[0], 0);
            chk("bp_hold", od[0], 8'h66);
            chk("bp_cnt", cnt0, held_cnt);
        end
        out_ready = 1'b1; tick(); chk("bp_release", od[0], 8'hFF);
        chk("sat", cnt1, 3);

        drv(1, 8'h12, 8'h34, 1, 0, 0); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_flush", ov[0], 0);
        drv(1, 8'hF0, 8'hCC, 0, 0, 1); tick(); chk("rst_table", od[0], 8'hC0);

        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_sel    = 2'($urandom_range(0, 3));
            in_chain  = ($urandom_range(0, 2) == 0);
            cfg_we    = ($urandom_range(0, 4) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_func  = 4'($urandom);
            rst       = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
